proj3_session_arbiter: RTL and testbench

Session scheduler that shares one csm51a_proj3 sequence-detector FSM between two requesters. It grants exclusive sessions, holds the FSM in clear between sessions, and streams each owner's 2-bit symbols {x1,x0} into it, one per cycle. It returns the FSM outputs {z1,z0} to the owner, tagged with its ID. It sits between the requester logic and the FSM instance and drives the FSM's clear and x1/x0 inputs directly.

---
 rtl/proj3_pkg.sv | 16 +
 rtl/proj3_rr_pick.sv | 33 +++
 rtl/proj3_session_arbiter.sv | 125 ++++++++++++
 tb/tb_proj3_session_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/proj3_pkg.sv
// Shared types and constants for the proj3 session arbiter.
//   state_e  : arbiter FSM states (StIdle, StRun)
//   sym_t    : 2-bit FSM input symbol {x1,x0}
//   req_id_t : requester identifier (0 or 1)
//   MaxBurstDefault : default maximum symbols per session
package proj3_pkg;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  typedef logic [1:0] sym_t;

  typedef logic req_id_t;

  localparam int unsigned MaxBurstDefault = 8;

endpackage

// File: rtl/proj3_rr_pick.sv
// Two-way session winner picker, purely combinational.
// Configuration macro: PROJ3_ARB_FIXED_PRI_EN selects fixed priority (requester 0 wins ties);
// when undefined, a tie goes to the requester that did not own the last session.
// Ports:
//   req_i  : request bits, one per requester
//   last_i : owner of the most recently ended session
//   any_o  : at least one request present
//   win_o  : ID of the selected requester (valid when any_o)
module proj3_rr_pick
  import proj3_pkg::*;
(
  input  logic [1:0] req_i,
  input  req_id_t    last_i,
  output logic       any_o,
  output req_id_t    win_o
);

  always_comb begin
    any_o = |req_i;
    win_o = 1'b0;
    if (req_i == 2'b11) begin
`ifdef PROJ3_ARB_FIXED_PRI_EN
      win_o = 1'b0;
`else
      win_o = ~last_i;
`endif
    end else begin
      // Lone requester (or none): requester 1 only if it is the one asking.
      win_o = req_i[1];
    end
  end

endmodule

// File: rtl/proj3_session_arbiter.sv
// Session scheduler sharing one csm51a_proj3 sequence-detector FSM between two requesters.
// The FSM cannot stall, so a session streams one symbol per cycle and ends on the first gap
// or after MAX_BURST symbols; the FSM is held in clear whenever no session is active.
// Configuration macro: PROJ3_ARB_FIXED_PRI_EN (fixed priority, tested in proj3_rr_pick only).
// Ports:
//   clock_i, clear_i        : clock, synchronous active-high reset
//   req_i, sym_vld_i        : per-requester session request and symbol valid
//   sym0_i, sym1_i          : per-requester symbol {x1,x0}
//   sym_rdy_o               : symbol accepted this cycle (combinational)
//   gnt_o                   : one-hot session owner (registered)
//   fsm_clear_o, fsm_x1/x0_o: drive the shared FSM
//   fsm_z1_i, fsm_z0_i      : FSM outputs
//   rsp_vld_o, rsp_id_o, rsp_z_o : response valid, owner tag and {z1,z0}
module proj3_session_arbiter
  import proj3_pkg::*;
#(
  parameter int unsigned MAX_BURST = MaxBurstDefault
) (
  input  logic       clock_i,
  input  logic       clear_i,
  input  logic [1:0] req_i,
  input  logic [1:0] sym0_i,
  input  logic [1:0] sym1_i,
  input  logic [1:0] sym_vld_i,
  output logic [1:0] sym_rdy_o,
  output logic [1:0] gnt_o,
  output logic       fsm_clear_o,
  output logic       fsm_x1_o,
  output logic       fsm_x0_o,
  input  logic       fsm_z1_i,
  input  logic       fsm_z0_i,
  output logic       rsp_vld_o,
  output logic       rsp_id_o,
  output logic [1:0] rsp_z_o
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(MAX_BURST - 1);

  state_e          state_q, state_d;
  req_id_t         owner_q, owner_d;
  req_id_t         last_q, last_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rsp_vld_q;
  req_id_t         rsp_id_q;

  logic    accept;
  sym_t    fsm_x;
  logic    pick_any;
  req_id_t pick_win;

  proj3_rr_pick u_pick (
    .req_i  (req_i),
    .last_i (last_q),
    .any_o  (pick_any),
    .win_o  (pick_win)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    sym_rdy_o = 2'b00;
    fsm_x     = 2'b00;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          state_d = StRun;
          owner_d = pick_win;
          gnt_d   = pick_win ? 2'b10 : 2'b01;
          cnt_d   = '0;
        end
      end
      StRun: begin
        // Clear suppresses the accept so no symbol is reported as taken during reset.
        accept = req_i[owner_q] & sym_vld_i[owner_q] & ~clear_i;
        if (accept) begin
          sym_rdy_o = owner_q ? 2'b10 : 2'b01;
          fsm_x     = owner_q ? sym1_i : sym0_i;
          cnt_d     = cnt_q + CntW'(1);
        end
        if (!accept || (cnt_q == LastCnt)) begin
          state_d = StIdle;
          gnt_d   = 2'b00;
          last_d  = owner_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (clear_i) begin
      state_q   <= StIdle;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      gnt_q     <= 2'b00;
      cnt_q     <= '0;
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      rsp_vld_q <= accept;
      rsp_id_q  <= owner_q;
    end
  end

  assign gnt_o       = gnt_q;
  assign fsm_clear_o = clear_i | (state_q == StIdle);
  assign fsm_x1_o    = fsm_x[1];
  assign fsm_x0_o    = fsm_x[0];
  assign rsp_vld_o   = rsp_vld_q;
  assign rsp_id_o    = rsp_id_q;
  // FSM state after the accepted symbol's edge is still intact in the following cycle.
  assign rsp_z_o     = rsp_vld_q ? {fsm_z1_i, fsm_z0_i} : 2'b00;

endmodule

// File: tb/tb_proj3_session_arbiter.sv
// Randomized bench for proj3_session_arbiter against a session-level reference model.
// A stand-in FSM (running XOR of symbols since its last clear) drives fsm_z, so the
// expected response is the XOR of all symbols accepted so far in the session.
module tb_proj3_session_arbiter;

  localparam int unsigned MB = 4;

  logic       clk = 1'b0;
  logic       clear;
  logic [1:0] req, sym0, sym1, sym_vld;
  logic [1:0] sym_rdy, gnt, rsp_z;
  logic       fsm_clear, fsm_x1, fsm_x0, fsm_z1, fsm_z0, rsp_vld, rsp_id;
  logic [1:0] fsm_z_q;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  proj3_session_arbiter #(.MAX_BURST(MB)) dut (
    .clock_i     (clk),
    .clear_i     (clear),
    .req_i       (req),
    .sym0_i      (sym0),
    .sym1_i      (sym1),
    .sym_vld_i   (sym_vld),
    .sym_rdy_o   (sym_rdy),
    .gnt_o       (gnt),
    .fsm_clear_o (fsm_clear),
    .fsm_x1_o    (fsm_x1),
    .fsm_x0_o    (fsm_x0),
    .fsm_z1_i    (fsm_z1),
    .fsm_z0_i    (fsm_z0),
    .rsp_vld_o   (rsp_vld),
    .rsp_id_o    (rsp_id),
    .rsp_z_o     (rsp_z)
  );

  // Stand-in for the shared sequence detector.
  always @(posedge clk) begin
    if (fsm_clear) fsm_z_q <= 2'b00;
    else           fsm_z_q <= fsm_z_q ^ {fsm_x1, fsm_x0};
  end
  assign fsm_z1 = fsm_z_q[1];
  assign fsm_z0 = fsm_z_q[0];

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: session-level bookkeeping.
  bit       m_in_sess = 0;
  bit       m_owner   = 0;
  bit       m_last    = 1;
  int       m_count   = 0;
  bit       m_prev_acc = 0;
  bit       m_prev_own = 0;
  bit [1:0] m_xor     = 0;
  int       sessions_0 = 0, sessions_1 = 0, caps = 0;

  task automatic step_and_check(input string phase);
    bit       acc;
    bit [1:0] e_x, e_rdy, e_gnt, e_rz, osym;
    bit       e_clr;
    bit       win;
    #1;
    osym  = m_owner ? sym1 : sym0;
    acc   = m_in_sess && !clear && req[m_owner] && sym_vld[m_owner];
    e_rdy = acc ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
    e_x   = acc ? osym : 2'b00;
    e_gnt = m_in_sess ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
    e_clr = clear || !m_in_sess;
    e_rz  = m_prev_acc ? m_xor : 2'b00;

    check_eq({phase, ".sym_rdy"}, {6'd0, sym_rdy}, {6'd0, e_rdy});
    check_eq({phase, ".fsm_x"}, {6'd0, fsm_x1, fsm_x0}, {6'd0, e_x});
    check_eq({phase, ".gnt"}, {6'd0, gnt}, {6'd0, e_gnt});
    check_eq({phase, ".fsm_clear"}, {7'd0, fsm_clear}, {7'd0, e_clr});
    check_eq({phase, ".rsp_vld"}, {7'd0, rsp_vld}, {7'd0, m_prev_acc});
    check_eq({phase, ".rsp_z"}, {6'd0, rsp_z}, {6'd0, e_rz});
    if (m_prev_acc) check_eq({phase, ".rsp_id"}, {7'd0, rsp_id}, {7'd0, m_prev_own});

    // Advance model to the state after the coming edge.
    m_xor = e_clr ? 2'b00 : (m_xor ^ e_x);
    m_prev_acc = acc;
    m_prev_own = m_owner;
    if (clear) begin
      m_in_sess = 0; m_last = 1; m_count = 0; m_owner = 0;
      m_prev_acc = 0; m_prev_own = 0;
    end else if (!m_in_sess) begin
      if (req != 2'b00) begin
`ifdef PROJ3_ARB_FIXED_PRI_EN
        win = (req == 2'b10);
`else
        win = (req == 2'b11) ? !m_last : (req == 2'b10);
`endif
        m_in_sess = 1; m_owner = win; m_count = 0;
        if (win) sessions_1++; else sessions_0++;
      end
    end else begin
      if (acc) m_count++;
      if (!acc || m_count == MB) begin
        if (acc) caps++;
        m_in_sess = 0; m_last = m_owner;
      end
    end
  endtask

  task automatic cycle(input string phase);
    @(negedge clk);
    step_and_check(phase);
  endtask

  initial begin
    clear = 1'b1; req = 2'b11; sym0 = 2'b00; sym1 = 2'b00; sym_vld = 2'b00;
    // Reset with both requesting: nothing granted while clear is high.
    cycle("reset0");
    cycle("reset1");
    @(negedge clk); clear = 1'b0; step_and_check("release");
    @(negedge clk); step_and_check("first_gnt");
    check_eq("first_gnt_is_req0", {6'd0, gnt}, 8'h01);

    // Single session from requester 0: 01,10,11 then gap.
    @(negedge clk); req = 2'b00; step_and_check("gap");
    @(negedge clk); step_and_check("idle");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req = 2'b01;
      sym_vld = (i >= 1 && i <= 3) ? 2'b01 : 2'b00;
      sym0 = 2'(i);
      step_and_check("single");
    end

    // Continuous demand from requester 1 exercises the burst cap.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      req = 2'b10; sym_vld = 2'b10; sym1 = 2'($urandom_range(0, 3));
      step_and_check("burst");
    end

    // Both continuously requesting: alternating owners.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      req = 2'b11; sym_vld = 2'b11;
      sym0 = 2'($urandom_range(0, 3)); sym1 = 2'($urandom_range(0, 3));
      step_and_check("rr");
    end

    // Randomized traffic with occasional mid-session clear.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      clear   = ($urandom_range(0, 99) < 3);
      req     = {($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 8)};
      sym_vld = {($urandom_range(0, 19) < 17), ($urandom_range(0, 19) < 17)};
      sym0    = 2'($urandom_range(0, 3));
      sym1    = 2'($urandom_range(0, 3));
      step_and_check("rand");
    end

    @(negedge clk); clear = 1'b0; req = 2'b00; sym_vld = 2'b00;
    step_and_check("drain0");
    cycle("drain1");
    cycle("drain2");

    check_eq("saw_req0_sessions", {7'd0, (sessions_0 > 10)}, 8'd1);
    check_eq("saw_req1_sessions", {7'd0, (sessions_1 > 10)}, 8'd1);
    check_eq("saw_burst_caps", {7'd0, (caps > 3)}, 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
